// File: rtl/load_store_unit.sv
// Initiator side of the big-endian, byte-addressed data-memory port: turns byte/half/word
// loads and stores into word-granular MemRead/MemWrite cycles; sub-word stores use read-modify-write.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        misaligned,
    output logic        out_of_range,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWriteData,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] MemReadData
);

    localparam logic [29:0] WORD_LIMIT = 30'(MEM_BYTES / 4);

    typedef enum logic [1:0] {IDLE, RD, CAP, WR} stateT;
    stateT state, stateNext;

    logic        isStoreQ, unsignedQ;
    logic [1:0]  sizeQ, laneQ;
    logic [15:0] wdataQ;

    logic        reqHalf, reqWord, reqMis, reqOor;
    logic [7:0]  selByte;
    logic [15:0] selHalf;
    logic [31:0] loadVal, mergedWord;

    logic [31:0] rdataN, memAddrN, memWdN;
    logic        busyN, doneN, misN, oorN, memReadN, memWriteN;

    // size 11 is handled as a word everywhere, hence size[1] alone selects word
    assign reqHalf = (size == 2'b01);
    assign reqWord = size[1];
    assign reqMis  = (reqHalf && addr[0]) || (reqWord && (addr[1:0] != 2'b00));
    assign reqOor  = (addr[31:2] >= WORD_LIMIT);

    always_comb begin
        selByte = MemReadData[7:0];
        case (laneQ)
            2'd0:    selByte = MemReadData[31:24];
            2'd1:    selByte = MemReadData[23:16];
            2'd2:    selByte = MemReadData[15:8];
            default: selByte = MemReadData[7:0];
        endcase
        selHalf = laneQ[1] ? MemReadData[15:0] : MemReadData[31:16];

        if (sizeQ[1])
            loadVal = MemReadData;
        else if (sizeQ[0])
            loadVal = {{16{~unsignedQ & selHalf[15]}}, selHalf};
        else
            loadVal = {{24{~unsignedQ & selByte[7]}}, selByte};

        mergedWord = MemReadData;
        if (sizeQ == 2'b00) begin
            case (laneQ)
                2'd0:    mergedWord[31:24] = wdataQ[7:0];
                2'd1:    mergedWord[23:16] = wdataQ[7:0];
                2'd2:    mergedWord[15:8]  = wdataQ[7:0];
                default: mergedWord[7:0]   = wdataQ[7:0];
            endcase
        end else if (laneQ[1]) begin
            mergedWord[15:0] = wdataQ;
        end else begin
            mergedWord[31:16] = wdataQ;
        end
    end

    always_comb begin
        stateNext = state;
        rdataN    = rdata;
        memAddrN  = MemAddr;
        memWdN    = MemWriteData;
        doneN     = 1'b0;
        misN      = 1'b0;
        oorN      = 1'b0;
        memReadN  = 1'b0;
        memWriteN = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (reqMis || reqOor) begin
                        doneN = 1'b1;
                        misN  = reqMis;
                        oorN  = reqOor;
                    end else begin
                        memAddrN = {addr[31:2], 2'b00};
                        if (is_store && reqWord) begin
                            stateNext = WR;
                            memWriteN = 1'b1;
                            memWdN    = wdata;
                        end else begin
                            stateNext = RD;
                            memReadN  = 1'b1;
                        end
                    end
                end
            end
            RD: stateNext = CAP;
            CAP: begin
                if (isStoreQ) begin
                    stateNext = WR;
                    memWriteN = 1'b1;
                    memWdN    = mergedWord;
                end else begin
                    stateNext = IDLE;
                    rdataN    = loadVal;
                    doneN     = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
                doneN     = 1'b1;
            end
        endcase
        busyN = (stateNext != IDLE);
    end

    // Strobes and flags are registered copies of the next-state decode so every output is a flop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rdata        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            misaligned   <= 1'b0;
            out_of_range <= 1'b0;
            MemAddr      <= '0;
            MemWriteData <= '0;
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
            isStoreQ     <= 1'b0;
            unsignedQ    <= 1'b0;
            sizeQ        <= '0;
            laneQ        <= '0;
            wdataQ       <= '0;
        end else begin
            state        <= stateNext;
            rdata        <= rdataN;
            busy         <= busyN;
            done         <= doneN;
            misaligned   <= misN;
            out_of_range <= oorN;
            MemAddr      <= memAddrN;
            MemWriteData <= memWdN;
            MemRead      <= memReadN;
            MemWrite     <= memWriteN;
            if (state == IDLE && req) begin
                isStoreQ  <= is_store;
                unsignedQ <= load_unsigned;
                sizeQ     <= size;
                laneQ     <= addr[1:0];
                wdataQ    <= wdata[15:0];
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array reference memory predicts each transaction;
// a negedge monitor checks strobes, latency, flags and load data as the DUT produces them.
module tb_load_store_unit;
    localparam int unsigned MEM_BYTES = 256;
    localparam int unsigned WORDS     = MEM_BYTES / 4;

    logic        clk = 1'b0, reset = 1'b1, req = 1'b0, is_store = 1'b0, load_unsigned = 1'b0;
    logic [1:0]  size = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata, MemAddr, MemWriteData, MemReadData;
    logic        busy, done, misaligned, out_of_range, MemRead, MemWrite;

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .reset(reset), .req(req), .is_store(is_store), .size(size),
        .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata), .rdata(rdata),
        .busy(busy), .done(done), .misaligned(misaligned), .out_of_range(out_of_range),
        .MemAddr(MemAddr), .MemWriteData(MemWriteData), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemReadData(MemReadData)
    );

    always #5 clk = ~clk;

    int tests = 0, failures = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] dmem [WORDS];
    logic [31:0] memRd = '0;
    logic [7:0]  refMem [MEM_BYTES];
    logic [31:0] heldRdata = '0;
    assign MemReadData = memRd;

    typedef struct {
        int unsigned doneCyc;
        logic        mis;
        logic        oor;
        logic [31:0] rdata;
        int          rdN;
        int          wrN;
        logic [31:0] memAddr;
    } expT;
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wrT;
    expT expQ[$];
    wrT  wrQ[$];
    int  rdCnt = 0, wrCnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory slave: read data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (MemRead) memRd <= (MemAddr[31:2] < WORDS) ? dmem[int'(MemAddr[31:2])] : '0;
        if (MemWrite && MemAddr[31:2] < WORDS) dmem[int'(MemAddr[31:2])] = MemWriteData;
    end

    always @(negedge clk) begin
        expT e;
        wrT  w;
        if (reset) begin
            rdCnt = 0;
            wrCnt = 0;
        end else begin
            if (MemRead && MemWrite) check("strobeOverlap", 32'd1, 32'd0);
            if (MemRead) begin
                rdCnt++;
                if (expQ.size() > 0) check("rdAddr", MemAddr, expQ[0].memAddr);
            end
            if (MemWrite) begin
                wrCnt++;
                if (wrQ.size() == 0) check("unexpectedWrite", MemAddr, 32'hFFFFFFFF);
                else begin
                    w = wrQ.pop_front();
                    check("wrAddr", MemAddr, w.a);
                    check("wrData", MemWriteData, w.d);
                end
            end
            if (done) begin
                if (expQ.size() == 0) check("spuriousDone", 32'd1, 32'd0);
                else begin
                    e = expQ.pop_front();
                    check("doneCycle", cyc, e.doneCyc);
                    check("misaligned", 32'(misaligned), 32'(e.mis));
                    check("outOfRange", 32'(out_of_range), 32'(e.oor));
                    check("rdata", rdata, e.rdata);
                    check("readCount", rdCnt, e.rdN);
                    check("writeCount", wrCnt, e.wrN);
                end
                rdCnt = 0;
                wrCnt = 0;
            end else if (misaligned || out_of_range) begin
                check("flagsOutsideDone", {30'd0, misaligned, out_of_range}, 32'd0);
            end
        end
    end

    // Reference: alignment means address is a multiple of the access size; bytes are stored MSB-first
    task automatic predict(input logic st, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, input int unsigned c0,
                           output bit fault);
        int n, base;
        logic [31:0] v;
        expT e;
        wrT w;
        n = sz[1] ? 4 : (sz == 2'b01 ? 2 : 1);
        e.mis = (a % n) != 0;
        e.oor = (a / 4) >= WORDS;
        e.memAddr = a & ~32'd3;
        e.rdata = heldRdata;
        e.rdN = 0;
        e.wrN = 0;
        fault = e.mis || e.oor;
        if (fault) begin
            e.doneCyc = c0 + 1;
        end else if (!st) begin
            v = 0;
            for (int i = 0; i < n; i++) v = (v << 8) | 32'(refMem[int'(a) + i]);
            if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
            heldRdata = v;
            e.rdata = v;
            e.rdN = 1;
            e.doneCyc = c0 + 3;
        end else begin
            for (int i = 0; i < n; i++) refMem[int'(a) + i] = 8'(wd >> (8*(n-1-i)));
            base = int'(a & ~32'd3);
            w.a = a & ~32'd3;
            w.d = {refMem[base], refMem[base+1], refMem[base+2], refMem[base+3]};
            wrQ.push_back(w);
            e.rdN = (n < 4) ? 1 : 0;
            e.wrN = 1;
            e.doneCyc = c0 + 1 + ((n == 4) ? 1 : 3);
        end
        expQ.push_back(e);
    endtask

    task automatic scramble();
        addr = $urandom;
        wdata = $urandom;
        size = 2'($urandom);
        is_store = 1'($urandom);
        load_unsigned = 1'($urandom);
    endtask

    task automatic waitDone(input string name);
        for (int i = 0; i < 10 && !done; i++) begin
            @(posedge clk); #1;
        end
        if (!done) begin
            tests++;
            failures++;
            $display("FAIL %s timeout: done=%b required 1", name, done);
            expQ.delete();
            wrQ.delete();
        end
    endtask

    // Returns #1 after the edge that raised done, so rdata is valid and the next call is back-to-back
    task automatic doReq(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input bit poke);
        bit fault;
        @(negedge clk);
        predict(st, sz, uns, a, wd, cyc, fault);
        is_store = st; size = sz; load_unsigned = uns; addr = a; wdata = wd; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        scramble();
        if (poke && !fault) begin
            req = 1'b1;
            @(posedge clk); #1;
            req = 1'b0;
            scramble();
        end
        waitDone("doReq");
    endtask

    initial begin
        bit f;
        logic [1:0] sz;
        logic [31:0] a;
        int unsigned r;
        for (int w = 0; w < WORDS; w++) begin
            dmem[w] = $urandom;
            for (int b = 0; b < 4; b++) refMem[4*w+b] = 8'(dmem[w] >> (24 - 8*b));
        end

        repeat (2) @(posedge clk);
        #1;
        check("rstRdata", rdata, 32'd0);
        check("rstMemAddr", MemAddr, 32'd0);
        check("rstMemWriteData", MemWriteData, 32'd0);
        check("rstCtl", {26'd0, busy, done, misaligned, out_of_range, MemRead, MemWrite}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        doReq(1, 2'b10, 0, 32'h14, 32'h11223344, 0);
        doReq(0, 2'b10, 0, 32'h14, 32'h0, 0);
        check("lw14", rdata, 32'h11223344);
        doReq(0, 2'b00, 0, 32'h15, 32'h0, 0);
        check("lb15", rdata, 32'h00000022);
        doReq(1, 2'b00, 0, 32'h17, 32'h00000080, 0);
        doReq(0, 2'b00, 0, 32'h17, 32'h0, 0);
        check("lb17", rdata, 32'hFFFFFF80);
        doReq(0, 2'b00, 1, 32'h17, 32'h0, 0);
        check("lbu17", rdata, 32'h00000080);
        doReq(1, 2'b01, 0, 32'h16, 32'hAAAABEEF, 0);
        doReq(0, 2'b10, 0, 32'h14, 32'h0, 0);
        check("lwAfterSh", rdata, 32'h1122BEEF);
        doReq(0, 2'b10, 0, 32'h15, 32'h0, 0);
        check("lw15Mis", {misaligned, out_of_range}, 2'b10);
        doReq(0, 2'b10, 0, 32'h100, 32'h0, 0);
        check("lw100Oor", {misaligned, out_of_range}, 2'b01);
        doReq(0, 2'b01, 0, 32'h101, 32'h0, 0);
        check("lh101Both", {misaligned, out_of_range}, 2'b11);
        check("faultKeepsRdata", rdata, 32'h1122BEEF);

        // Reset while the sub-word store sits in CAP: the pending write must never appear
        @(negedge clk);
        is_store = 1'b1; size = 2'b00; load_unsigned = 1'b0; addr = 32'h14; wdata = 32'h55; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        check("rmwReadStrobe", {MemRead, MemWrite, busy}, 3'b101);
        @(posedge clk); #1;
        check("rmwCapState", {MemRead, MemWrite, busy}, 3'b001);
        #2 reset = 1'b1;
        #1;
        check("rstMidStrobes", {MemRead, MemWrite, busy, done}, 4'b0000);
        check("rstMidRdata", rdata, 32'd0);
        heldRdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        doReq(0, 2'b10, 0, 32'h14, 32'h0, 0);
        check("wordAfterAbort", rdata, 32'h1122BEEF);

        // req held high from a load straight into a word store
        @(negedge clk);
        predict(0, 2'b10, 0, 32'h14, 32'h0, cyc, f);
        is_store = 1'b0; size = 2'b10; load_unsigned = 1'b0; addr = 32'h14; req = 1'b1;
        @(posedge clk); #1;
        waitDone("b2bLoad");
        predict(1, 2'b10, 0, 32'h18, 32'hCAFEF00D, cyc, f);
        is_store = 1'b1; addr = 32'h18; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req = 1'b0;
        check("b2bAccepted", {31'd0, busy}, 32'd1);
        waitDone("b2bStore");

        doReq(0, 2'b10, 0, 32'h18, 32'h0, 1);
        check("lwAfterPoke", rdata, 32'hCAFEF00D);

        for (int t = 0; t < 200; t++) begin
            sz = 2'($urandom);
            r = $urandom % 16;
            if (r == 0) a = $urandom;
            else if (r < 3) a = $urandom_range(MEM_BYTES + 15, MEM_BYTES);
            else a = $urandom_range(MEM_BYTES - 1, 0);
            if ($urandom % 4 != 0) a = a & ~(sz[1] ? 32'd3 : (sz[0] ? 32'd1 : 32'd0));
            doReq(1'($urandom), sz, 1'($urandom), a, $urandom, ($urandom % 4) == 0);
        end

        repeat (4) @(negedge clk);
        check("expQueueEmpty", expQ.size(), 32'd0);
        check("wrQueueEmpty", wrQ.size(), 32'd0);
        for (int w = 0; w < WORDS; w++)
            check("finalMem", dmem[w], {refMem[4*w], refMem[4*w+1], refMem[4*w+2], refMem[4*w+3]});

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: converts CPU load/store requests (byte, half, word; signed or unsigned loads) into word-granular MemRead/MemWrite cycles on the byte-addressed, big-endian data memory.
- Sub-word stores are done as read-modify-write.
- Loads are sign- or zero-extended.
- Misaligned and out-of-range accesses fault without touching memory.
- Sits between the MEM pipeline stage and the data memory.

Parameters:
- MEM_BYTES, 256, size of the data memory in bytes; must be a multiple of 4.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  request; sampled only in IDLE.
- is_store  input  1  1 = store, 0 = load.
- size  input  2  00 = byte, 01 = half, 10 = word; 11 is illegal and treated as word.
- load_unsigned  input  1  1 = zero-extend, 0 = sign-extend; ignored for word and stores.
- addr  input  32  byte address.
- wdata  input  32  store data; the byte or half is taken from the low bits.
- rdata  output  32  load result; valid while done=1 and held until the next load completes.
- busy  output  1  1 whenever state is not IDLE.
- done  output  1  one-cycle completion pulse, asserted for both success and fault.
- misaligned  output  1  valid with done; half with addr[0]=1, or word with addr[1:0]!=0.
- out_of_range  output  1  valid with done; addr[31:2] >= MEM_BYTES/4.
- MemAddr  output  32  always word-aligned: {addr[31:2],2'b00}.
- MemWriteData  output  32  word written when MemWrite=1.
- MemRead  output  1  read strobe to memory.
- MemWrite  output  1  write strobe to memory.
- MemReadData  input  32  memory output; valid in the cycle after a MemRead cycle.

Behaviour:
- Reset (async, immediate): state IDLE; MemRead=0, MemWrite=0, done=0, misaligned=0, out_of_range=0, busy=0, rdata=0, MemAddr=0, MemWriteData=0.
- Reset mid-operation aborts the transaction; no pending MemWrite is issued afterwards.
- All outputs are registered. addr, size, is_store, load_unsigned and wdata are latched at the accepting edge; later input changes have no effect.
- FSM states: IDLE, RD, CAP, WR.
- IDLE, req=1 at edge E0, fault case (misaligned has priority; out_of_range may also be set): done=1 with the fault flag(s) for one cycle after E0. State stays IDLE. No MemRead or MemWrite. rdata is unchanged.
- IDLE, req=1, load or sub-word store: go to RD.
- IDLE, req=1, word store: go to WR with MemWriteData=wdata.
- RD: MemRead=1 for exactly one cycle, with MemAddr driven. The memory captures on the next edge. Next state is CAP.
- CAP: MemRead=0; MemReadData is valid.
  - Load: rdata is extracted and extended at the next edge, done=1, state returns to IDLE.
  - Sub-word store: the merged word is registered into MemWriteData, next state is WR.
- WR: MemWrite=1 for exactly one cycle. Next state IDLE with done=1.
- Big-endian lane select, with k = addr[1:0]:
  - Byte k = MemReadData[31-8k -: 8].
  - Half at k=0 is [31:16]; half at k=2 is [15:0].
  - Merge replaces only the selected lane with wdata[7:0] or wdata[15:0].
- Latency, counted from the accepting edge to the edge that raises done:
  - Load: 2 cycles.
  - Word store: 1 cycle.
  - Sub-word store: 3 cycles.
  - Fault: 0 extra (done is visible right after E0).
- MemRead and MemWrite are never high in the same cycle. Each is high for at most one cycle per transaction.
- req while busy is ignored; it is not queued.
- req=1 at the edge where done is high (state is IDLE) is accepted, so back-to-back requests work. The requester must drop req in the done cycle to avoid a repeat.
- done, misaligned and out_of_range are 0 in every cycle other than the done pulse.

Test Plan:
- Word store then word load: sw addr=0x14, wdata=0x11223344 → one MemWrite cycle with MemAddr=0x14 and MemWriteData=0x11223344, done 1 cycle later. Then lw 0x14 → rdata=0x11223344, done 2 cycles after accept.
- Byte loads: lb 0x15 → 0x00000022. Store byte 0x80 at 0x17 via sb, then lb 0x17 → 0xFFFFFF80 and lbu 0x17 → 0x00000080.
- Sub-word RMW: with word 0x11223344 at 0x14, sh addr=0x16, wdata=0xAAAABEEF → sequence MemRead, CAP, MemWrite with MemWriteData=0x1122BEEF; then lw 0x14 → 0x1122BEEF.
- Faults: lw 0x15 → done=1, misaligned=1, no strobes. lw 0x100 with MEM_BYTES=256 → done=1, out_of_range=1, no strobes. lh 0x101 → both flags set.
- Reset mid-RMW: assert reset during CAP of sb 0x14 → strobes drop immediately, no MemWrite ever issued, memory word unchanged, busy=0.
- Back-to-back and busy: hold req high through lw 0x14 followed by sw 0x18 → the second request is accepted on the done edge. A req pulse during RD is ignored, with no extra done.
